// File: rtl/uart_rx_fifo_if.sv
// Pop/status bundle between the UART receiver and the SOC IO read path.
// The SOC side is the master (pops and clears); the receiver is the slave.
interface uart_rx_fifo_if;
   logic       rstrb;
   logic       ovr_clr;
   logic [7:0] rdata;
   logic       rdata_valid;
   logic       overrun;
   logic       frame_err;

   modport master (output rstrb, ovr_clr,
                   input  rdata, rdata_valid, overrun, frame_err);
   modport slave  (input  rstrb, ovr_clr,
                   output rdata, rdata_valid, overrun, frame_err);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a receive buffer for the SOC IO page.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
//
// state | meaning
// ARM   | wait for idle-high line before accepting a start bit
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit, reject glitches
// DATA  | sampling 8 data bits LSB first
// STOP  | sampling stop bit; push byte or flag framing error
module uart_rx_fifo #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 1000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           rxd,
   uart_rx_fifo_if.slave  bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 8 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_rx_fifo: CLKS_PER_BIT must be >= 8 and FIFO_DEPTH a power of two >= 2");
   end

   typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          push, ferr_d, ferr_q, ovr_q, ovr_set;
   logic          rxs;

   assign rxs = sync_q[1];

   always_ff @(posedge clk) begin
      if (resetn) begin
         sync_q  <= 2'b11;
         state_q <= ARM;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rxd};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         ferr_q  <= ferr_d;
      end
   end

   // cnt is a down-counter; every sample happens at its terminal count of zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      push    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         ARM:   if (rxs) state_d = IDLE;
         IDLE:  if (!rxs) begin
                   state_d = START;
                   cnt_d   = HALF_TC;
                end
         START: if (cnt_q == '0) begin
                   if (rxs) state_d = IDLE;
                   else begin
                      state_d = DATA;
                      cnt_d   = BIT_TC;
                      idx_d   = '0;
                   end
                end else cnt_d = cnt_q - 1'b1;
         DATA:  if (cnt_q == '0) begin
                   sh_d[idx_q] = rxs;
                   cnt_d       = BIT_TC;
                   if (idx_q == 3'd7) state_d = STOP;
                   else idx_d = idx_q + 3'd1;
                end else cnt_d = cnt_q - 1'b1;
         STOP:  if (cnt_q == '0) begin
                   if (rxs) begin
                      push    = 1'b1;
                      state_d = IDLE;
                   end else begin
                      ferr_d  = 1'b1;
                      state_d = ARM;
                   end
                end else cnt_d = cnt_q - 1'b1;
         default: state_d = ARM;
      endcase
   end

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_q, rd_q;
   logic        empty, full, do_wr, do_pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   // a pop alongside a push on an empty buffer consumes the incoming byte
   assign do_pop  = bus.rstrb && (!empty || push);
   assign do_wr   = push && (!full || bus.rstrb);
   assign ovr_set = push && full && !bus.rstrb;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_q[AW-1:0]] <= sh_q;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_wr)  wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
      end
   end

   assign bus.rdata_valid = !empty;
   assign bus.rdata       = empty ? 8'h00 : mem[rd_q[AW-1:0]];
`else
   logic [7:0] hold_q;
   logic       valid_q, do_wr, do_pop;

   assign do_pop  = bus.rstrb && (valid_q || push);
   assign do_wr   = push && (!valid_q || bus.rstrb);
   assign ovr_set = push && valid_q && !bus.rstrb;

   always_ff @(posedge clk) begin
      if (resetn) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (do_wr) hold_q <= sh_q;
         if (do_wr != do_pop) valid_q <= do_wr;
      end
   end

   assign bus.rdata_valid = valid_q;
   assign bus.rdata       = valid_q ? hold_q : 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (resetn)           ovr_q <= 1'b0;
      else if (ovr_set)     ovr_q <= 1'b1;
      else if (bus.ovr_clr) ovr_q <= 1'b0;
   end

   assign bus.overrun   = ovr_q;
   assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frame sequences plus random pops, checked
// cycle by cycle against a queue model of the receive buffer.
module tb_uart_rx_fifo;
   localparam int CPB = 100;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`ifdef UART_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic resetn, rxd;
   uart_rx_fifo_if bus ();

   uart_rx_fifo #(.CLK_FREQ_HZ(100000000), .BAUD_RATE(1000000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .rxd(rxd), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   int         sched_cyc [64];
   logic [7:0] sched_val [64];
   bit         sched_ok  [64];
   int         n_sched = 0, sch_rd = 0;

   int pop_req = 0, pop_done = 0, clr_req = 0, clr_done = 0;
   int pop_at = -1, rand_pct = 0, clr_pct = 0;

   logic [7:0] mq [$];
   bit m_ovr = 1'b0, m_ferr = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // reference model: the buffer is a plain queue updated at every clock edge
   always @(posedge clk) begin
      bit ev_push, ev_ferr, set;
      logic [7:0] ev_val;
      cyc++;
      ev_push = 1'b0; ev_ferr = 1'b0; set = 1'b0; ev_val = 8'h00;
      if (sch_rd < n_sched && sched_cyc[sch_rd] == cyc) begin
         if (sched_ok[sch_rd]) ev_push = 1'b1;
         else ev_ferr = 1'b1;
         ev_val = sched_val[sch_rd];
         sch_rd++;
      end
      if (resetn) begin
         mq.delete();
         m_ovr = 1'b0;
         m_ferr = 1'b0;
      end else begin
         m_ferr = ev_ferr;
         if (ev_push && bus.rstrb) begin
            if (mq.size() > 0) begin
               void'(mq.pop_front());
               mq.push_back(ev_val);
            end
         end else if (ev_push) begin
            if (int'(mq.size()) < DEPTH) mq.push_back(ev_val);
            else set = 1'b1;
         end else if (bus.rstrb && mq.size() > 0) begin
            void'(mq.pop_front());
         end
         if (set) m_ovr = 1'b1;
         else if (bus.ovr_clr) m_ovr = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("rdata", int'(bus.rdata), (mq.size() > 0) ? int'(mq[0]) : 0);
         chk("rdata_valid", int'(bus.rdata_valid), (mq.size() > 0) ? 1 : 0);
         chk("overrun", int'(bus.overrun), int'(m_ovr));
         chk("frame_err", int'(bus.frame_err), int'(m_ferr));
      end
   end

   initial begin
      bus.rstrb = 1'b0;
      bus.ovr_clr = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.rstrb = (pop_req != pop_done) || (pop_at == cyc + 1) || ($urandom_range(99) < rand_pct);
         if (pop_req != pop_done) pop_done++;
         bus.ovr_clr = (clr_req != clr_done) || ($urandom_range(199) < clr_pct);
         if (clr_req != clr_done) clr_done++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit sched,
                            input bit pop_push, input int abort_bit);
      int t0;
      rxd = 1'b0;
      t0 = cyc;
      if (sched && n_sched < 64) begin
         sched_cyc[n_sched] = t0 + LAT;
         sched_val[n_sched] = b;
         sched_ok[n_sched]  = stop_ok;
         n_sched++;
      end
      if (pop_push) pop_at = t0 + LAT;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         if (i == abort_bit) begin
            tick(CPB / 2);
            resetn = 1'b1;
            tick(1);
            resetn = 1'b0;
            tick(CPB / 2 - 1);
         end else tick(CPB);
      end
      rxd = stop_ok;
      tick(CPB);
      rxd = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_byte(b, 1'b1, 1'b1, 1'b0, -1);
   endtask

   task automatic pop();
      pop_req++;
      tick(2);
   endtask

   task automatic clr();
      clr_req++;
      tick(2);
   endtask

   initial begin
      logic [7:0] rb;
      int k;
      resetn = 1'b1;
      rxd = 1'b1;
      mon_en = 1'b1;
      tick(3);
      resetn = 1'b0;
      chk("rst_rdata", int'(bus.rdata), 0);
      chk("rst_valid", int'(bus.rdata_valid), 0);
      chk("rst_overrun", int'(bus.overrun), 0);
      chk("rst_frame_err", int'(bus.frame_err), 0);

      // single byte; latency is enforced by the per-cycle model compare
      tick(200);
      send(8'hA5);
      tick(3);
      chk("t1_rdata", int'(bus.rdata), 'hA5);
      pop();
      chk("t1_pop_valid", int'(bus.rdata_valid), 0);
      chk("t1_pop_rdata", int'(bus.rdata), 0);

      // glitch, framing error, recovery
      rxd = 1'b0;
      tick(30);
      rxd = 1'b1;
      tick(200);
      chk("t2_glitch_valid", int'(bus.rdata_valid), 0);
      send_byte(8'h3C, 1'b0, 1'b1, 1'b0, -1);
      tick(20);
      chk("t2_ferr_valid", int'(bus.rdata_valid), 0);
      send(8'h11);
      tick(3);
      chk("t2_rdata", int'(bus.rdata), 'h11);
      pop();

      // fill past capacity
      for (int i = 1; i <= 5; i++) send(8'(i));
      tick(3);
      chk("t3_overrun", int'(bus.overrun), 1);
      chk("t3_head", int'(bus.rdata), 1);
      for (int i = 0; i < 5; i++) pop();
      chk("t3_drained", int'(bus.rdata_valid), 0);
      clr();
      chk("t3_ovr_clr", int'(bus.overrun), 0);

      // push and pop in the same cycle while full
      for (int i = 1; i <= 4; i++) send(8'(i));
      clr();
      send_byte(8'h55, 1'b1, 1'b1, 1'b1, -1);
      tick(3);
      chk("t4_overrun", int'(bus.overrun), 0);
`ifdef UART_RX_FIFO_EN
      chk("t4_head", int'(bus.rdata), 'h02);
`else
      chk("t4_head", int'(bus.rdata), 'h55);
`endif
      for (int i = 0; i < 5; i++) pop();
      for (int r = 0; r < 3; r++) begin
         k = $urandom_range(2, 5);
         for (int i = 0; i < k; i++) begin
            rb = 8'($urandom);
            send(rb);
         end
         tick(3);
         chk("t4_fill_valid", int'(bus.rdata_valid), 1);
         for (int i = 0; i < 5; i++) pop();
         clr();
      end

      // reset in the middle of a frame
      send_byte(8'hF0, 1'b1, 1'b0, 1'b0, 4);
      tick(20);
      chk("t5_abort_valid", int'(bus.rdata_valid), 0);
      send(8'h7E);
      tick(3);
      chk("t5_rdata", int'(bus.rdata), 'h7E);
      pop();

      // two bytes without popping
      clr();
      send(8'h10);
      send(8'h20);
      tick(5);
      chk("t6_rdata", int'(bus.rdata), 'h10);
`ifdef UART_RX_FIFO_EN
      chk("t6_overrun", int'(bus.overrun), 0);
`else
      chk("t6_overrun", int'(bus.overrun), 1);
`endif
      pop();
`ifdef UART_RX_FIFO_EN
      chk("t6_pop_rdata", int'(bus.rdata), 'h20);
`else
      chk("t6_pop_valid", int'(bus.rdata_valid), 0);
`endif
      for (int i = 0; i < 3; i++) pop();

      // random traffic with random pops and clears
      rand_pct = 2;
      clr_pct = 1;
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom);
         send(rb);
         tick($urandom_range(0, 30));
      end
      rand_pct = 0;
      clr_pct = 0;
      tick(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
